// File: rtl/score_display_pkg.sv
// Shared constants for the seven-segment score display blocks: segment codes,
// the blank code, FSM state encoding and channel selection.
package score_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        CH_SCORE = 1'b0,
        CH_HIGH  = 1'b1
    } chan_e;

    // Active-low segments, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] CONV_BITS = 4'd8;

endpackage

// File: rtl/score_display_seg7.sv
// Combinational BCD digit to active-low seven-segment decoder.
module seg7_decoder
    import score_display_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_display.sv
// Score and high-score seven-segment display driven by one shared
// bit-serial double-dabble binary-to-BCD converter.
module score_display
    import score_display_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic [7:0] hi_score,
    output logic       busy
);

    state_e      state_q, state_d;
    chan_e       chan_q, chan_d;
    logic [19:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  last_score_q, last_score_d;
    logic [7:0]  last_hi_q, last_hi_d;
    logic [7:0]  hi_q, hi_d;
    logic [6:0]  hex0_q, hex1_q, hex2_q, hex3_q, hex4_q, hex5_q;
    logic [6:0]  hex0_d, hex1_d, hex2_d, hex3_d, hex4_d, hex5_d;
    logic [6:0]  seg_u, seg_t, seg_h;
    logic [6:0]  disp_u, disp_t, disp_h;

    // One double-dabble iteration: BCD lives in [19:8], binary in [7:0]
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] r;
        r = v;
        for (int n = 0; n < 3; n++) begin
            if (r[8 + 4*n +: 4] >= 4'd5)
                r[8 + 4*n +: 4] = r[8 + 4*n +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

    seg7_decoder u_dec_units (.digit_i(sr_q[11:8]),  .seg_o(seg_u));
    seg7_decoder u_dec_tens  (.digit_i(sr_q[15:12]), .seg_o(seg_t));
    seg7_decoder u_dec_hund  (.digit_i(sr_q[19:16]), .seg_o(seg_h));

    always_comb begin
        disp_u = seg_u;
        disp_h = (sr_q[19:16] == 4'd0) ? SEG_BLANK : seg_h;
        disp_t = (sr_q[19:12] == 8'd0) ? SEG_BLANK : seg_t;
    end

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        last_score_d = last_score_q;
        last_hi_d    = last_hi_q;
        hi_d         = (score > hi_q) ? score : hi_q;
        hex0_d       = hex0_q;
        hex1_d       = hex1_q;
        hex2_d       = hex2_q;
        hex3_d       = hex3_q;
        hex4_d       = hex4_q;
        hex5_d       = hex5_q;
        case (state_q)
            ST_IDLE: begin
                if (score != last_score_q) begin
                    sr_d         = {12'd0, score};
                    last_score_d = score;
                    chan_d       = CH_SCORE;
                    cnt_d        = 4'd0;
                    state_d      = ST_CONV;
                end else if (hi_q != last_hi_q) begin
                    sr_d      = {12'd0, hi_q};
                    last_hi_d = hi_q;
                    chan_d    = CH_HIGH;
                    cnt_d     = 4'd0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                // Extra cycle after the last shift keeps the 10-edge latency
                if (cnt_q == CONV_BITS) begin
                    state_d = ST_DONE;
                end else begin
                    sr_d  = dabble_step(sr_q);
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                if (chan_q == CH_SCORE) begin
                    hex0_d = disp_u;
                    hex1_d = disp_t;
                    hex2_d = disp_h;
                end else begin
                    hex3_d = disp_u;
                    hex4_d = disp_t;
                    hex5_d = disp_h;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            chan_q       <= CH_SCORE;
            sr_q         <= 20'd0;
            cnt_q        <= 4'd0;
            last_score_q <= 8'd0;
            last_hi_q    <= 8'd0;
            hi_q         <= 8'd0;
            hex0_q       <= SEG_0;
            hex1_q       <= SEG_BLANK;
            hex2_q       <= SEG_BLANK;
            hex3_q       <= SEG_0;
            hex4_q       <= SEG_BLANK;
            hex5_q       <= SEG_BLANK;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            last_score_q <= last_score_d;
            last_hi_q    <= last_hi_d;
            hi_q         <= hi_d;
            hex0_q       <= hex0_d;
            hex1_q       <= hex1_d;
            hex2_q       <= hex2_d;
            hex3_q       <= hex3_d;
            hex4_q       <= hex4_d;
            hex5_q       <= hex5_d;
        end
    end

    assign hex0     = hex0_q;
    assign hex1     = hex1_q;
    assign hex2     = hex2_q;
    assign hex3     = hex3_q;
    assign hex4     = hex4_q;
    assign hex5     = hex5_q;
    assign hi_score = hi_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed scenarios plus a random
// score walk checked against a decimal/running-maximum reference model.
module tb_score_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] score = 8'd0;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [7:0] hi_score;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int hi_model = 0;

    localparam logic [6:0] BLANK = 7'b1111111;
    logic [6:0] segtab [10];

    score_display dut (
        .clk(clk), .rst(rst), .score(score),
        .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .hi_score(hi_score), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected {hundreds, tens, units} segment group for a decimal value
    function automatic logic [20:0] disp(input int v);
        int h, t, u;
        logic [6:0] sh, st, su;
        h  = v / 100;
        t  = (v / 10) % 10;
        u  = v % 10;
        sh = (h == 0) ? BLANK : segtab[h];
        st = (h == 0 && t == 0) ? BLANK : segtab[t];
        su = segtab[u];
        return {sh, st, su};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        score = 8'd0;
        hi_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Wait until the converter has been idle for three consecutive cycles
    task automatic wait_settle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 3) begin
            errors++;
            checks++;
            $display("FAIL settle_%s: busy still active after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic test_reset();
        logic rose = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        score = 8'd0;
        #1;
        checks++;
        if ({hex2, hex1, hex0} !== {BLANK, BLANK, segtab[0]}) begin
            errors++;
            $display("FAIL reset_score_group: got %b required %b", {hex2, hex1, hex0}, {BLANK, BLANK, segtab[0]});
        end
        checks++;
        if ({hex5, hex4, hex3} !== {BLANK, BLANK, segtab[0]}) begin
            errors++;
            $display("FAIL reset_high_group: got %b required %b", {hex5, hex4, hex3}, {BLANK, BLANK, segtab[0]});
        end
        checks++;
        if (hi_score !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hi_busy: got hi=%0d busy=%b required hi=0 busy=0", hi_score, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0) rose = 1'b1;
        end
        checks++;
        if (rose !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_conv: busy rose=%b required 0", rose);
        end
        checks++;
        if ({hex2, hex1, hex0} !== disp(0)) begin
            errors++;
            $display("FAIL reset_hold_display: got %b required %b", {hex2, hex1, hex0}, disp(0));
        end
    endtask

    task automatic test_latency();
        do_reset();
        score = 8'd10;
        hi_model = 10;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_busy: got %b required 1", busy);
        end
        for (int k = 1; k <= 21; k++) begin
            @(posedge clk);
            #1;
            if (k == 9) begin
                checks++;
                if (hex1 !== BLANK) begin
                    errors++;
                    $display("FAIL latency_early_hex1: edge %0d got %b required %b", k, hex1, BLANK);
                end
            end
            if (k == 10) begin
                checks++;
                if ({hex1, hex0} !== {segtab[1], segtab[0]}) begin
                    errors++;
                    $display("FAIL latency_score: got %b required %b", {hex1, hex0}, {segtab[1], segtab[0]});
                end
            end
            if (k == 20) begin
                checks++;
                if (hex4 !== BLANK) begin
                    errors++;
                    $display("FAIL latency_early_hex4: got %b required %b", hex4, BLANK);
                end
            end
            if (k == 21) begin
                checks++;
                if ({hex4, hex3} !== {segtab[1], segtab[0]}) begin
                    errors++;
                    $display("FAIL latency_high: got %b required %b", {hex4, hex3}, {segtab[1], segtab[0]});
                end
            end
        end
        wait_settle("latency");
    endtask

    task automatic test_max_and_lose();
        do_reset();
        score = 8'd255;
        wait_settle("max");
        checks++;
        if ({hex2, hex1, hex0} !== {7'b0100100, 7'b0010010, 7'b0010010}) begin
            errors++;
            $display("FAIL max_score_group: got %b required %b", {hex2, hex1, hex0}, {7'b0100100, 7'b0010010, 7'b0010010});
        end
        score = 8'd0;
        wait_settle("lose");
        checks++;
        if ({hex2, hex1, hex0} !== disp(0)) begin
            errors++;
            $display("FAIL lose_score_group: got %b required %b", {hex2, hex1, hex0}, disp(0));
        end
        checks++;
        if ({hex5, hex4, hex3} !== disp(255) || hi_score !== 8'd255) begin
            errors++;
            $display("FAIL lose_high_kept: got %b hi=%0d required %b hi=255", {hex5, hex4, hex3}, hi_score, disp(255));
        end
    endtask

    task automatic test_glitch();
        logic saw40 = 1'b0;
        do_reset();
        score = 8'd30;
        repeat (3) @(negedge clk);
        score = 8'd40;
        repeat (2) @(negedge clk);
        score = 8'd30;
        repeat (40) begin
            @(negedge clk);
            if ({hex2, hex1, hex0} === disp(40)) saw40 = 1'b1;
        end
        wait_settle("glitch");
        checks++;
        if (saw40 !== 1'b0 || {hex2, hex1, hex0} !== disp(30)) begin
            errors++;
            $display("FAIL glitch_score: saw40=%b display %b required saw40=0 display %b", saw40, {hex2, hex1, hex0}, disp(30));
        end
        checks++;
        if (hi_score !== 8'd40 || {hex5, hex4, hex3} !== disp(40)) begin
            errors++;
            $display("FAIL glitch_high: hi=%0d display %b required hi=40 display %b", hi_score, {hex5, hex4, hex3}, disp(40));
        end
    endtask

    task automatic test_reset_mid();
        logic bad = 1'b0;
        do_reset();
        score = 8'd120;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        score = 8'd0;
        #1;
        checks++;
        if ({hex5, hex4, hex3, hex2, hex1, hex0} !== {BLANK, BLANK, segtab[0], BLANK, BLANK, segtab[0]}
            || busy !== 1'b0 || hi_score !== 8'd0) begin
            errors++;
            $display("FAIL midreset_immediate: hex=%b busy=%b hi=%0d required reset values",
                     {hex5, hex4, hex3, hex2, hex1, hex0}, busy, hi_score);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if ({hex2, hex1, hex0} === disp(120) || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL midreset_abandon: 120 shown or conversion restarted=%b required 0", bad);
        end
    endtask

    task automatic test_random();
        int v;
        do_reset();
        for (int step = 0; step < 1000; step++) begin
            v = int'($urandom_range(0, 255));
            score = v[7:0];
            if (v > hi_model) hi_model = v;
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end else begin
                wait_settle("random");
                checks++;
                if ({hex2, hex1, hex0} !== disp(v)) begin
                    errors++;
                    $display("FAIL random_score step %0d: got %b required %b (score %0d)", step, {hex2, hex1, hex0}, disp(v), v);
                end
                checks++;
                if (hi_score !== hi_model[7:0]) begin
                    errors++;
                    $display("FAIL random_hi step %0d: got %0d required %0d", step, hi_score, hi_model);
                end
                checks++;
                if ({hex5, hex4, hex3} !== disp(hi_model)) begin
                    errors++;
                    $display("FAIL random_high_group step %0d: got %b required %b", step, {hex5, hex4, hex3}, disp(hi_model));
                end
            end
        end
    endtask

    initial begin
        segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
        segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
        segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
        segtab[9] = 7'b0010000;
        test_reset();
        test_latency();
        test_max_and_lose();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_display.md
SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 Parameters: none; the block is fixed at an 8-bit score and 3 decimal digits per value.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 score  input  8  current game score from the score counter, unsigned 0..255.
REQ-005 hex0, hex1, hex2  output  7 each  score units/tens/hundreds, segments gfedcba, active-low, registered.
REQ-006 hex3, hex4, hex5  output  7 each  high-score units/tens/hundreds, same encoding, registered.
REQ-007 hi_score  output  8  highest score seen since reset, registered.
REQ-008 busy  output  1  high while a binary-to-BCD conversion is in flight.

Function
REQ-009 hi_score SHALL load score on any cycle where score > hi_score, visible one cycle later; it never decreases except at reset.
REQ-010 Conversion SHALL use one shared sequential shift-and-add-3 (double-dabble) converter, one bit per clock.
REQ-011 The FSM SHALL have states IDLE, CONV and DONE.
REQ-012 In IDLE, if score != last_score, the block SHALL capture score into the shift register, set last_score <= score, select channel SCORE, clear the bit counter and go to CONV.
REQ-013 Otherwise in IDLE, if hi_score != last_hi, it SHALL capture hi_score the same way, set last_hi <= hi_score, select channel HIGH and go to CONV; score has priority when both differ.
REQ-014 CONV SHALL perform exactly 8 iterations (add 3 to any BCD nibble >= 5, then shift left one bit), then go to DONE.
REQ-015 DONE SHALL write the three BCD digits, segment-encoded, into the output group of the selected channel only, then return to IDLE.
REQ-016 Latency: the hex outputs SHALL change exactly 10 rising edges after the IDLE edge that captured the value.
REQ-017 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-018 Input changes during CONV/DONE SHALL NOT disturb the running conversion; the new value is picked up at the next IDLE because it differs from last_score/last_hi.
REQ-019 Intermediate score values that change and return before IDLE SHALL NOT be displayed.
REQ-020 Segment codes, 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-021 Leading-zero blanking: the hundreds digit SHALL be blank (1111111) when 0; the tens digit SHALL be blank when both hundreds and tens are 0; units is never blanked.
REQ-022 Score 255 SHALL display as 2,5,5; wrap of the upstream score to a smaller value SHALL be displayed as-is, with hi_score retained.

Reset
REQ-023 On rst low, immediately and regardless of the FSM state: state=IDLE, hi_score=0, last_score=0, last_hi=0, busy=0, hex0=hex3=1000000 ("0"), and hex1, hex2, hex4, hex5 = 1111111 (blank).
REQ-024 A reset mid-conversion SHALL abandon the conversion with no partial output update.
REQ-025 After reset release with score=0, no conversion SHALL start.

Structure
REQ-026 The segment code constants, the blank code and the FSM state encoding SHALL live in a shared package used by all display blocks.
REQ-027 The digit-to-segment mapping SHALL be one combinational sub-module, seg7_decoder (4-bit in, 7-bit active-low out), instantiated per digit.

Verification
REQ-028 Reset with score=0 -> hex0=1000000, hex1..2 blank, hex3=1000000, busy never rises.
REQ-029 score 0->10 at edge N -> busy at N+1; hex1=1111001 and hex0=1000000 at N+10; the high channel then converts 10 and hex4/hex3 update 10 edges later.
REQ-030 score 255 -> hex2=0100100, hex1=0010010, hex0=0010010; then score 0 (lose) -> score digits show "0" and hex5..3 still show 255.
REQ-031 score 30->40->30 within one conversion -> final score display 30, never 40; hi_score=40.
REQ-032 rst asserted 5 cycles into a conversion of 120 -> all outputs take reset values immediately; no "120" is ever shown.
REQ-033 Random score sequence of 1000 steps -> the settled display always equals the decimal of score, and hi_score equals the running maximum.
